rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
//
// PURPOSE
// - Shares one WIDTH-bit output channel among N_REQ requesters.
// - Round-robin arbitration selects the requester; a mux tree steers its data.
// - One registered output stage with valid/ready on both sides.
// - Sits between several producer blocks and a single shared consumer.
//
// PARAMETERS
// - N_REQ  4  number of requesters, >=1, any value (not limited to powers of 2)
// - WIDTH  8  data width per requester
//
// PORTS
// - clk        in   1              single clock, rising edge
// - rst        in   1              reset: asynchronous, active-high
// - req_valid  in   N_REQ          per-requester valid
// - req_data   in   N_REQ*WIDTH    requester i occupies bits [i*WIDTH +: WIDTH]
// - req_ready  out  N_REQ          per-requester ready (one-hot or zero)
// - out_valid  out  1              output beat valid (registered)
// - out_data   out  WIDTH          output beat data (registered)
// - out_ready  in   1              consumer ready
// - grant_idx  out  $clog2(N_REQ)  source index of the held beat (width 1 when N_REQ=1)
//
// BEHAVIOUR
// - Reset (async assert): out_valid=0, out_data=0, grant_idx=0, rr pointer ptr=0.
//   A beat held at reset is discarded.
// - States:
//   - EMPTY: out_valid=0.
//   - FULL: out_valid=1; beat stable until out_ready=1.
// - Load window: load = !out_valid | out_ready.
// - Arbitration runs only when load=1:
//   - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping N_REQ-1 -> 0.
//   - req_ready[winner]=1 only; all other req_ready bits are 0.
//   - load=0: req_ready is all zeros.
// - req_ready is combinational from req_valid, ptr, out_valid and out_ready.
//   No combinational path from req_data.
// - On accept:
//   - out_data <= req_data[winner], grant_idx <= winner, out_valid <= 1.
//   - ptr <= (winner == N_REQ-1) ? 0 : winner+1.
// - Load with no requests: out_valid <= 0; ptr and grant_idx unchanged.
// - Timing:
//   - Latency 1 cycle, accept -> out_valid.
//   - Throughput 1 beat/cycle while out_ready=1.
//   - Simultaneous drain and accept in the same cycle is required (no bubble).
// - Fairness: each continuously-valid requester is served within N_REQ beats.
// - N_REQ=1: degenerates to a plain register slice; grant_idx is constant 0.
// - Requesters must hold req_valid/req_data until accepted; the arbiter does not check this.
//
// CONFIGURATION
// - Macro RR_MUX_ARB_PKT_LOCK_EN.
// - Defined:
//   - Adds ports req_last (in, N_REQ) and out_last (out, 1, reset 0, registered with out_data).
//   - After a beat with last=0 is accepted from i, only i is eligible.
//   - Arbitration reopens after i's beat with last=1 is accepted.
//   - ptr advances only on last beats.
//   - Reset clears the lock.
// - Undefined:
//   - No last ports.
//   - Every beat is arbitrated independently as above.
//
// TESTING
// 1. rst=1 while out_valid=1 -> immediately out_valid=0, out_data=0, grant_idx=0; first
//    post-reset grant searches from 0.
// 2. N_REQ=4, all req_valid=1, out_ready=1, data=8'hA0+i -> grant_idx 0,1,2,3,0 on consecutive
//    cycles; out_data A0,A1,A2,A3,A0.
// 3. Only req 2 valid, out_ready=1 -> req_ready=4'b0100 every cycle; 1 beat/cycle;
//    grant_idx=2 throughout.
// 4. out_valid=1, out_ready=0 for 3 cycles -> out_data/grant_idx stable, req_ready=0;
//    out_ready=1 -> drain + new accept in same cycle.
// 5. ptr=3 (after granting 2), req 1 and 3 valid -> grants 3 then 1; ptr wraps to 0 then 2.
// 6. PKT_LOCK_EN: req0 sends 3 beats (last on third), req1 valid throughout
//    -> grants 0,0,0,1; out_last=0,0,1,x.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// rr_mux_arbiter -- round-robin N:1 arbiter with a registered valid/ready
// output stage. Optional packet lock under RR_MUX_ARB_PKT_LOCK_EN.
// Revision: 1.0
// ============================================================================
module rr_mux_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef RR_MUX_ARB_PKT_LOCK_EN
  input  logic [N_REQ-1:0]       req_last,
  output logic                   out_last,
`endif
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       grant_idx
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] eligible;
  logic             load;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W:0]   cand;
  logic [WIDTH-1:0] win_data;

`ifdef RR_MUX_ARB_PKT_LOCK_EN
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             last_q, last_d;
  logic             win_last;

  // While a packet is in flight only its owner may compete.
  always_comb begin
    eligible = lock_q ? (req_valid & (N_REQ'(1) << lock_idx_q)) : req_valid;
  end
`else
  always_comb begin
    eligible = req_valid;
  end
`endif

  assign out_valid = (state_q == FULL);
  assign load      = !out_valid || out_ready;

  // Search ptr, ptr+1, ... wrapping at N_REQ (not necessarily a power of two).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
    win_last = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        win_data = req_data[i*WIDTH +: WIDTH];
`ifdef RR_MUX_ARB_PKT_LOCK_EN
        win_last = req_last[i];
`endif
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (load && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign next_ptr = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    last_d     = last_q;
`endif
    if (load) begin
      if (found) begin
        state_d = FULL;
        data_d  = win_data;
        idx_d   = winner;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
        last_d     = win_last;
        lock_d     = !win_last;
        lock_idx_d = winner;
        if (win_last) begin
          ptr_d = next_ptr;
        end
`else
        ptr_d = next_ptr;
`endif
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_MUX_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      last_q     <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      last_q     <= last_d;
    end
  end

  assign out_last = last_q;
`endif

  assign out_data  = data_q;
  assign grant_idx = idx_q;

endmodule
`default_nettype wire
